// File: rtl/ser_if.sv
// Parallel-word handshake plus one-bit serial data/valid pair of the serializer.
// The master modport is the upstream/observer side, the slave modport is the serializer itself.
interface ser_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ready_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ready_o, ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ready_o, ser_data_o, ser_data_val_o, busy_o
  );
endinterface

// File: rtl/serializer.sv
// MSB-first parallel-to-serial transmitter with a one-word holding buffer,
// so consecutive words leave the block with no idle cycle between them.
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
) (
  input logic   clk_i,
  input logic   arst_n_i,
  ser_if.slave  bus
);
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_SHIFT = 1'b1;
  localparam logic [MOD_W:0] LEN_FULL = (MOD_W + 1)'(DATA_W);
  localparam logic [MOD_W:0] LEN_ONE  = (MOD_W + 1)'(1);
  localparam logic [MOD_W:0] LEN_TWO  = (MOD_W + 1)'(2);

  logic [DATA_W-1:0] sh_r, sh_s;
  logic [MOD_W:0]    cnt_r, cnt_s;
  logic [DATA_W-1:0] hb_data_r, hb_data_s;
  logic [MOD_W:0]    hb_len_r, hb_len_s;
  logic              hb_full_r, hb_full_s;

  logic [0:0]        state_s;
  logic [MOD_W:0]    len_s;
  logic              take_s;

  // Decode the offered word: effective length and whether a legal word is handed over.
  always_comb begin
    len_s = '0;
    if (bus.data_mod_i == '0) begin
      len_s = LEN_FULL;
    end else begin
      len_s = {1'b0, bus.data_mod_i};
    end
    // Lengths 1 and 2 are consumed by the handshake but otherwise dropped.
    take_s  = bus.data_val_i & ~hb_full_r & (len_s > LEN_TWO);
    state_s = (cnt_r != '0) ? ST_SHIFT : ST_IDLE;
  end

  // Next-state logic for the shifter and the holding buffer.
  always_comb begin
    sh_s      = sh_r;
    cnt_s     = cnt_r;
    hb_data_s = hb_data_r;
    hb_len_s  = hb_len_r;
    hb_full_s = hb_full_r;
    case (state_s)
      ST_IDLE: begin
        if (take_s) begin
          sh_s  = bus.data_i;
          cnt_s = len_s;
        end else begin
          cnt_s = '0;
        end
      end
      ST_SHIFT: begin
        sh_s  = {sh_r[DATA_W-2:0], 1'b0};
        cnt_s = cnt_r - LEN_ONE;
        if (cnt_r == LEN_ONE) begin
          // Last bit on the wire: the buffered word wins over a fresh one.
          if (hb_full_r) begin
            sh_s      = hb_data_r;
            cnt_s     = hb_len_r;
            hb_full_s = 1'b0;
            if (take_s) begin
              hb_data_s = bus.data_i;
              hb_len_s  = len_s;
              hb_full_s = 1'b1;
            end else begin
              hb_data_s = hb_data_r;
            end
          end else if (take_s) begin
            sh_s  = bus.data_i;
            cnt_s = len_s;
          end else begin
            cnt_s = '0;
          end
        end else if (take_s) begin
          hb_data_s = bus.data_i;
          hb_len_s  = len_s;
          hb_full_s = 1'b1;
        end else begin
          hb_full_s = hb_full_r;
        end
      end
      default: begin
        cnt_s     = '0;
        hb_full_s = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any word in flight or buffered.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sh_r      <= '0;
      cnt_r     <= '0;
      hb_data_r <= '0;
      hb_len_r  <= '0;
      hb_full_r <= 1'b0;
    end else begin
      sh_r      <= sh_s;
      cnt_r     <= cnt_s;
      hb_data_r <= hb_data_s;
      hb_len_r  <= hb_len_s;
      hb_full_r <= hb_full_s;
    end
  end

  // Outputs decode register state only, so reset clears them without a clock.
  assign bus.ser_data_val_o = (cnt_r != '0);
  assign bus.ser_data_o     = (cnt_r != '0) & sh_r[DATA_W-1];
  assign bus.ready_o        = ~hb_full_r;
  assign bus.busy_o         = (cnt_r != '0) | hb_full_r;
endmodule
